instruction_sequencer: RTL

Fetch/decode/execute control FSM for the 8-bit CPU. It drives the program counter's control strobes (increment, load, relative-modify, plus the 8-bit extend value) and reads instruction bytes over a request/acknowledge memory port addressed by the current PC. It also latches the instruction register and issues one execute strobe per ALU instruction to the datapath.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/branch_resolve.sv | 50 +++++
 rtl/instruction_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, sequencer states
// and the two-byte instruction predicate.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_BR   = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_OPERAND = 3'd2,
    ST_OP_INC  = 3'd3,
    ST_EXECUTE = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  function automatic logic is_two_byte(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational EXECUTE decode: turns opcode/nibble/immediate/zero flag into
// the PC strobes, the ALU execute strobe and the extend value.
module branch_resolve
  import cpu_pkg::*;
#(
  parameter logic [3:0] HALT_OP = OP_HALT
) (
  input  logic [3:0] i_opcode,
  input  logic [3:0] i_nibble,
  input  logic [7:0] i_imm,
  input  logic       i_zero,
  output logic       o_pl,
  output logic       o_ms,
  output logic       o_exec,
  output logic [7:0] o_extend
);

  // Halt takes priority so a HALT_OP overlapping a control opcode never strobes.
  always_comb begin
    o_pl     = 1'b0;
    o_ms     = 1'b0;
    o_exec   = 1'b0;
    o_extend = 8'h00;
    if (i_opcode == HALT_OP) begin
      o_exec = 1'b0;
    end else begin
      case (i_opcode)
        OP_NOP: o_exec = 1'b0;
        OP_JMP: begin
          o_pl     = 1'b1;
          o_extend = i_imm;
        end
        OP_JZ: begin
          if (i_zero) begin
            o_pl     = 1'b1;
            o_extend = i_imm;
          end else begin
            o_pl = 1'b0;
          end
        end
        OP_BR: begin
          o_ms     = 1'b1;
          o_extend = {{4{i_nibble[3]}}, i_nibble};
        end
        default: o_exec = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute control FSM: reads instruction bytes over a req/ack port
// and drives registered PC strobes, the instruction register and the ALU strobe.
module instruction_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RST_IR  = 8'h00,
  parameter logic [3:0] HALT_OP = OP_HALT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_mem_data,
  input  logic       i_mem_ack,
  input  logic       i_zero,
  output logic       o_mem_rd,
  output logic       o_pi,
  output logic       o_pl,
  output logic       o_ms,
  output logic [7:0] o_extend,
  output logic [7:0] o_ir,
  output logic       o_exec,
  output logic       o_halt
);

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic       mem_rd_q, mem_rd_d;
  logic       pi_q, pi_d;
  logic       pl_q, pl_d;
  logic       ms_q, ms_d;
  logic       exec_q, exec_d;
  logic       halt_q, halt_d;
  logic [7:0] extend_q, extend_d;

  logic       br_pl_s, br_ms_s, br_exec_s;
  logic [7:0] br_extend_s;
  logic       to_exec_s;

  branch_resolve #(.HALT_OP(HALT_OP)) u_branch_resolve (
    .i_opcode (ir_q[7:4]),
    .i_nibble (ir_q[3:0]),
    .i_imm    (imm_q),
    .i_zero   (i_zero),
    .o_pl     (br_pl_s),
    .o_ms     (br_ms_s),
    .o_exec   (br_exec_s),
    .o_extend (br_extend_s)
  );

  // Next-state and byte capture; acks only count in states that request a read.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      ST_FETCH: begin
        if (i_mem_ack) begin
          ir_d    = i_mem_data;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_two_byte(ir_q[7:4])) begin
          state_d = ST_OPERAND;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_OPERAND: begin
        if (i_mem_ack) begin
          imm_d   = i_mem_data;
          state_d = ST_OP_INC;
        end else begin
          state_d = ST_OPERAND;
        end
      end
      ST_OP_INC: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (ir_q[7:4] == HALT_OP) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are computed for the state being entered so they register in step with it.
  always_comb begin
    to_exec_s = (state_d == ST_EXECUTE);
    mem_rd_d  = (state_d == ST_FETCH) || (state_d == ST_OPERAND);
    pi_d      = (state_d == ST_DECODE) || (state_d == ST_OP_INC);
    pl_d      = to_exec_s & br_pl_s;
    ms_d      = to_exec_s & br_ms_s;
    exec_d    = to_exec_s & br_exec_s;
    extend_d  = to_exec_s ? br_extend_s : 8'h00;
    halt_d    = (state_d == ST_HALT) || (to_exec_s && (ir_q[7:4] == HALT_OP));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= RST_IR;
      imm_q    <= 8'h00;
      mem_rd_q <= 1'b1;
      pi_q     <= 1'b0;
      pl_q     <= 1'b0;
      ms_q     <= 1'b0;
      exec_q   <= 1'b0;
      halt_q   <= 1'b0;
      extend_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      mem_rd_q <= mem_rd_d;
      pi_q     <= pi_d;
      pl_q     <= pl_d;
      ms_q     <= ms_d;
      exec_q   <= exec_d;
      halt_q   <= halt_d;
      extend_q <= extend_d;
    end
  end

  assign o_mem_rd = mem_rd_q;
  assign o_pi     = pi_q;
  assign o_pl     = pl_q;
  assign o_ms     = ms_q;
  assign o_exec   = exec_q;
  assign o_halt   = halt_q;
  assign o_extend = extend_q;
  assign o_ir     = ir_q;

endmodule
